// File: rtl/main_adc_pkg.sv
// rtl/main_adc_pkg.sv - shared types and defaults for the main ADC command path
package main_adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  localparam int ADC_CMD_W       = 16;
  localparam int ADC_SER_CLK_DIV = 4;

endpackage

// File: rtl/adc_ser_tick_gen.sv
// rtl/adc_ser_tick_gen.sv - half-period counter, one-cycle tick every CLK_DIV cycles while enabled
module adc_ser_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clearing while disabled guarantees a full low phase on the first bit of every word.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_cmd_serializer.sv
// rtl/adc_cmd_serializer.sv - parallel command word to framed MSB-first serial stream for the ADC
module adc_cmd_serializer
  import main_adc_pkg::*;
#(
  parameter int DATA_W   = ADC_CMD_W,
  parameter int CLK_DIV  = ADC_SER_CLK_DIV,
  parameter int IDLE_GAP = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_frame,
  output logic              busy
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int GAP_W = $clog2(IDLE_GAP) + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(IDLE_GAP - 1);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              ser_clk_q, ser_clk_d;
  logic              ser_data_q, ser_data_d;
  logic              ser_frame_q, ser_frame_d;
  logic              tick;
  logic              accept;
  logic              last_edge;

  adc_ser_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == SHIFT),
    .tick_o (tick)
  );

  assign accept    = (state_q == IDLE) && s_valid;
  assign last_edge = tick && ser_clk_q && (bit_cnt_q == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_edge) state_d = GAP;
      GAP:     if (gap_cnt_q == LAST_GAP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_ready     = (state_q == IDLE);
    busy        = (state_q != IDLE);
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    ser_clk_d   = ser_clk_q;
    ser_data_d  = ser_data_q;
    ser_frame_d = ser_frame_q;
    case (state_q)
      IDLE: begin
        gap_cnt_d = '0;
        if (accept) begin
          shreg_d     = s_data;
          bit_cnt_d   = '0;
          ser_data_d  = s_data[DATA_W-1];
          ser_frame_d = 1'b1;
          ser_clk_d   = 1'b0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!ser_clk_q) begin
            ser_clk_d = 1'b1;
          end else if (bit_cnt_q == LAST_BIT) begin
            ser_clk_d   = 1'b0;
            ser_data_d  = 1'b0;
            ser_frame_d = 1'b0;
          end else begin
            // Next bit goes out on the falling edge; rotate keeps it at bit DATA_W-2.
            ser_clk_d  = 1'b0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            shreg_d    = {shreg_q[DATA_W-2:0], shreg_q[DATA_W-1]};
            ser_data_d = shreg_q[DATA_W-2];
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: begin
        ser_clk_d   = 1'b0;
        ser_data_d  = 1'b0;
        ser_frame_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_frame_q <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_frame_q <= ser_frame_d;
    end
  end

  assign ser_clk   = ser_clk_q;
  assign ser_data  = ser_data_q;
  assign ser_frame = ser_frame_q;

endmodule

// File: tb/tb_adc_cmd_serializer.sv
// tb/tb_adc_cmd_serializer.sv - self-checking bench for adc_cmd_serializer
module tb_adc_cmd_serializer;

  localparam int W = 16;
  localparam int G = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [W-1:0] s_data;
  logic         s_valid;
  logic         sel;

  logic s_ready0, ser_clk0, ser_data0, ser_frame0, busy0;
  logic s_ready1, ser_clk1, ser_data1, ser_frame1, busy1;

  adc_cmd_serializer #(.DATA_W(W), .CLK_DIV(2), .IDLE_GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready0),
    .ser_clk(ser_clk0), .ser_data(ser_data0), .ser_frame(ser_frame0), .busy(busy0)
  );

  adc_cmd_serializer #(.DATA_W(W), .CLK_DIV(1), .IDLE_GAP(G)) dut_div1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready1),
    .ser_clk(ser_clk1), .ser_data(ser_data1), .ser_frame(ser_frame1), .busy(busy1)
  );

  logic m_ready, m_clk, m_data, m_frame, m_busy;
  assign m_ready = sel ? s_ready1   : s_ready0;
  assign m_clk   = sel ? ser_clk1   : ser_clk0;
  assign m_data  = sel ? ser_data1  : ser_data0;
  assign m_frame = sel ? ser_frame1 : ser_frame0;
  assign m_busy  = sel ? busy1      : busy0;

  int n_assert = 0;
  int n_fail   = 0;

  int           busy_cnt = 0;
  int           acc_cnt  = 0;
  bit           started  = 1'b0;
  logic [W-1:0] cur_word = '0;
  logic         prev_clk, prev_data, prev_frame;
  logic [W-1:0] coll;
  int           nrise, low_len, last_low_len;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: a frame is 2*cd*W cycles; in-frame cycle p shows bit W-1-p/(2cd) with ser_clk=(p/cd)%2.
  always @(negedge clk) begin
    int cdv;
    int n;
    int p;
    cdv = sel ? 1 : 2;
    n   = 2 * cdv * W + G;
    if (started) begin
      check("s_ready", 32'(m_ready), 32'(busy_cnt == 0));
      check("busy", 32'(m_busy), 32'(busy_cnt != 0));
      if (busy_cnt > G) begin
        p = n - busy_cnt;
        check("ser_frame", 32'(m_frame), 32'd1);
        check("ser_clk", 32'(m_clk), 32'((p / cdv) % 2));
        check("ser_data", 32'(m_data), 32'(cur_word[W-1-p/(2*cdv)]));
      end else begin
        check("idle_frame", 32'(m_frame), 32'd0);
        check("idle_clk", 32'(m_clk), 32'd0);
        check("idle_data", 32'(m_data), 32'd0);
      end
      if (m_clk && !prev_clk) begin
        check("data_stable_at_rise", 32'(m_data), 32'(prev_data));
        coll = {coll[W-2:0], m_data};
        nrise++;
      end
      if (m_frame && !prev_frame) last_low_len = low_len;
      if (m_frame) low_len = 0;
      else low_len++;
      if (!m_frame && prev_frame) begin
        check("word_at_rises", 32'(coll), 32'(cur_word));
        check("rise_count", 32'(nrise), 32'(W));
        coll  = '0;
        nrise = 0;
      end
      prev_clk   = m_clk;
      prev_data  = m_data;
      prev_frame = m_frame;
    end
    if (!rst_n) begin
      started    = 1'b1;
      busy_cnt   = 0;
      prev_clk   = 1'b0;
      prev_data  = 1'b0;
      prev_frame = 1'b0;
      coll       = '0;
      nrise      = 0;
      low_len    = 0;
    end else if (started) begin
      if (busy_cnt == 0 && s_valid === 1'b1) begin
        cur_word = s_data;
        busy_cnt = n;
        acc_cnt++;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
      end
    end
  end

  task automatic send(input logic [W-1:0] w, input bit keep);
    int n0;
    int k;
    n0      = acc_cnt;
    k       = 0;
    s_data  = w;
    s_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      k++;
    end while (acc_cnt == n0 && k < 5000);
    check("send_accepted", 32'(acc_cnt != n0), 32'd1);
    if (!keep) s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy_cnt != 0 && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check("wait_idle", 32'(busy_cnt == 0), 32'd1);
  endtask

  initial begin
    int k;
    int waited;
    int n0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    sel     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_ready", 32'(s_ready0), 32'd1);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_frame", 32'(ser_frame0), 32'd0);

    send(16'hA5C3, 1'b0);
    wait_idle();

    send(16'h8001, 1'b1);
    send(16'h7FFE, 1'b0);
    wait_idle();
    check("b2b_frame_low", 32'(last_low_len), 32'(G + 1));

    send(16'h0000, 1'b0);
    wait_idle();
    send(16'hFFFF, 1'b0);
    wait_idle();

    send(16'h5AA5, 1'b0);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ready", 32'(s_ready0), 32'd1);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_frame", 32'(ser_frame0), 32'd0);
    check("midrst_clk", 32'(ser_clk0), 32'd0);
    check("midrst_data", 32'(ser_data0), 32'd0);
    send(16'h1234, 1'b0);
    wait_idle();

    send(16'h3C5A, 1'b0);
    k = 0;
    while (!(busy_cnt > 0 && busy_cnt <= G) && k < 5000) begin
      @(posedge clk); #1;
      k++;
    end
    check("reached_gap", 32'(busy_cnt > 0 && busy_cnt <= G), 32'd1);
    k       = busy_cnt;
    n0      = acc_cnt;
    waited  = 0;
    s_valid = 1'b1;
    do begin
      s_data = W'($urandom);
      @(posedge clk); #1;
      waited++;
    end while (acc_cnt == n0 && waited < 100);
    s_valid = 1'b0;
    check("stall_accept_delay", 32'(waited), 32'(k + 1));
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 4)) @(posedge clk);
      #1;
      send(W'($urandom), bit'($urandom_range(0, 1)));
    end
    s_valid = 1'b0;
    wait_idle();

    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sel   = 1'b1;
    send(16'hF00F, 1'b0);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send(W'($urandom), bit'($urandom_range(0, 1)));
    end
    s_valid = 1'b0;
    wait_idle();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
